// File: rtl/uart_ram_bridge.sv
// UART byte-command to single-word SRAM access bridge (requester side).
// Optional done-wait timeout with 'E' reply: define RAM_TIMEOUT_EN.
module uart_ram_bridge #(
  parameter logic [7:0] OP_WRITE = 8'h57,
  parameter logic [7:0] OP_READ = 8'h52,
  parameter logic [7:0] ACK_BYTE = 8'h4B,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        ram_en,
  output logic        ram_re,
  output logic        ram_we,
  output logic [16:0] ram_addr,
  output logic [15:0] ram_wdata,
  input  logic        ram_done,
  input  logic [15:0] ram_rdata,
  output logic        busy,
  output logic        overrun
);

  typedef enum logic [3:0] {
    IDLE, ADDR2, ADDR1, ADDR0, DATAH, DATAL,
    ACCESS, GAP, TXH, TXL, TXACK
  } state_t;

  state_t state, state_n;
  logic        is_read;
  logic [16:0] addr;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        accept;
  logic        is_op;
  logic        err;

  assign accept = (state == IDLE) || (state == ADDR2) ||
                  (state == ADDR1) || (state == ADDR0) ||
                  (state == DATAH) || (state == DATAL);
  assign is_op = (rx_data == OP_WRITE) || (rx_data == OP_READ);

`ifdef RAM_TIMEOUT_EN
  localparam logic [15:0] TMAX = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] tcount;
  logic        expire;
  assign expire = (tcount == TMAX) && !ram_done;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:   if (rx_valid && is_op) state_n = ADDR2;
      ADDR2:  if (rx_valid) state_n = ADDR1;
      ADDR1:  if (rx_valid) state_n = ADDR0;
      ADDR0:  if (rx_valid) state_n = is_read ? ACCESS : DATAH;
      DATAH:  if (rx_valid) state_n = DATAL;
      DATAL:  if (rx_valid) state_n = ACCESS;
`ifdef RAM_TIMEOUT_EN
      ACCESS: if (ram_done || expire) state_n = GAP;
`else
      ACCESS: if (ram_done) state_n = GAP;
`endif
      GAP:    state_n = (is_read && !err) ? TXH : TXACK;
      TXH:    if (tx_ready) state_n = TXL;
      TXL:    if (tx_ready) state_n = IDLE;
      TXACK:  if (tx_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      is_read <= 1'b0;
      addr    <= '0;
      wdata   <= '0;
      rdata   <= '0;
      overrun <= 1'b0;
    end else begin
      if (rx_valid && accept) begin
        unique case (1'b1)
          state == IDLE:  if (is_op) is_read <= (rx_data == OP_READ);
          state == ADDR2: addr[16] <= rx_data[0];
          state == ADDR1: addr[15:8] <= rx_data;
          state == ADDR0: addr[7:0] <= rx_data;
          state == DATAH: wdata[15:8] <= rx_data;
          state == DATAL: wdata[7:0] <= rx_data;
          default: ;
        endcase
      end
      if (state == ACCESS && ram_done) rdata <= ram_rdata;
      // Bytes outside the command phase are lost; flag it until reset.
      if (rx_valid && !accept) overrun <= 1'b1;
    end
  end

`ifdef RAM_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      tcount <= '0;
      err    <= 1'b0;
    end else begin
      tcount <= (state == ACCESS) ? tcount + 16'd1 : 16'd0;
      if (state != ACCESS && state_n == ACCESS) err <= 1'b0;
      if (state == ACCESS && expire) err <= 1'b1;
    end
  end
`endif

  assign ram_en    = (state == ACCESS);
  assign ram_re    = ram_en && is_read;
  assign ram_we    = ram_en && !is_read;
  assign ram_addr  = addr;
  assign ram_wdata = wdata;
  assign busy      = (state != IDLE);

  always_comb begin
    tx_data  = 8'h00;
    tx_valid = 1'b0;
    unique case (state)
      TXH: begin
        tx_data  = rdata[15:8];
        tx_valid = 1'b1;
      end
      TXL: begin
        tx_data  = rdata[7:0];
        tx_valid = 1'b1;
      end
      TXACK: begin
        tx_data  = err ? 8'h45 : ACK_BYTE;
        tx_valid = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_uart_ram_bridge.sv
// Directed bench for uart_ram_bridge: RAM wrapper model plus tx scoreboard.
// Timeout section runs only when RAM_TIMEOUT_EN is defined.
module tb_uart_ram_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic        ram_en, ram_re, ram_we;
  logic [16:0] ram_addr;
  logic [15:0] ram_wdata;
  logic        ram_done = 1'b0;
  logic [15:0] ram_rdata = 16'h0000;
  logic        busy, overrun;

  uart_ram_bridge dut (
    .clk(clk), .rst(rst),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .ram_en(ram_en), .ram_re(ram_re), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_done(ram_done), .ram_rdata(ram_rdata),
    .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_chk = 0;
  int n_fail = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  logic        model_on = 1'b1;
  logic [15:0] model_rdata = 16'h0000;
  int          cnt = 0;
  logic        prev_en = 1'b0;
  logic [16:0] acc_addr = '0;
  logic [15:0] acc_wdata = '0;
  logic        acc_re = 1'b0, acc_we = 1'b0;
  int          en_cycles = 0;
  int          n_acc = 0;
  logic        unstable = 1'b0;

  // Wrapper model: done pulses on the 3rd cycle after en rises
  always @(posedge clk) begin
    if (rst) begin
      ram_done <= 1'b0;
      cnt <= 0;
    end else if (ram_done) begin
      ram_done <= 1'b0;
    end else if (ram_en && model_on) begin
      if (cnt == 2) begin
        ram_done <= 1'b1;
        ram_rdata <= model_rdata;
        cnt <= 0;
      end else begin
        cnt <= cnt + 1;
      end
    end
    if (!ram_en) cnt <= 0;
    if (ram_en && !prev_en) begin
      acc_addr <= ram_addr;
      acc_wdata <= ram_wdata;
      acc_re <= ram_re;
      acc_we <= ram_we;
      en_cycles <= 1;
      unstable <= 1'b0;
      n_acc <= n_acc + 1;
    end else if (ram_en) begin
      en_cycles <= en_cycles + 1;
      if (ram_addr !== acc_addr || ram_wdata !== acc_wdata ||
          ram_re !== acc_re || ram_we !== acc_we)
        unstable <= 1'b1;
    end
    prev_en <= ram_en;
  end

  always @(posedge clk) begin
    if (!rst && tx_valid && tx_ready) got_q.push_back(tx_data);
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int limit);
    int k = 0;
    while ((busy || got_q.size() < exp_q.size()) && k < limit) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_timeout"}, 64'(k < limit), 64'd1);
  endtask

  task automatic drain(input string tag);
    chk({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    while (exp_q.size() > 0 && got_q.size() > 0)
      chk(tag, 64'(got_q.pop_front()), 64'(exp_q.pop_front()));
    exp_q.delete();
    got_q.delete();
  endtask

  function automatic logic [63:0] outs();
    return 64'({tx_valid, tx_data, ram_en, ram_re, ram_we,
                ram_addr, ram_wdata, busy, overrun});
  endfunction

  initial begin
    int k;
    int a0;
    logic stable;
    repeat (3) @(negedge clk);
    chk("reset_outs", outs(), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_outs", outs(), 64'd0);

    // write
    exp_q.push_back(8'h4B);
    send(8'h57); send(8'h00); send(8'h12);
    send(8'h34); send(8'hAB); send(8'hCD);
    chk("wr_latency_en", 64'(ram_en), 64'd1);
    wait_idle("wr", 100);
    chk("wr_we_re", 64'({acc_we, acc_re}), 64'b10);
    chk("wr_addr", 64'(acc_addr), 64'h01234);
    chk("wr_wdata", 64'(acc_wdata), 64'hABCD);
    chk("wr_stable", 64'(unstable), 64'd0);
    chk("wr_en_cycles", 64'(en_cycles), 64'd4);
    drain("wr_tx");

    // read from RAM2, with turnaround measurement
    model_rdata = 16'h5A3C;
    exp_q.push_back(8'h5A);
    exp_q.push_back(8'h3C);
    send(8'h52); send(8'h01); send(8'h00); send(8'h05);
    k = 0;
    while (!ram_done && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("rd_done_seen", 64'(k < 50), 64'd1);
    k = 0;
    while (!tx_valid && k < 10) begin
      @(negedge clk);
      k++;
    end
    chk("rd_turnaround", 64'(k), 64'd2);
    wait_idle("rd", 100);
    chk("rd_we_re", 64'({acc_we, acc_re}), 64'b01);
    chk("rd_addr", 64'(acc_addr), 64'h10005);
    chk("rd_busy_after", 64'(busy), 64'd0);
    drain("rd_tx");

    // backpressure on the high byte
    model_rdata = 16'h1234;
    exp_q.push_back(8'h12);
    exp_q.push_back(8'h34);
    tx_ready = 1'b0;
    send(8'h52); send(8'h00); send(8'h00); send(8'h07);
    k = 0;
    while (!tx_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("bp_valid_seen", 64'(k < 50), 64'd1);
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (!(tx_valid === 1'b1 && tx_data === 8'h12)) stable = 1'b0;
      @(negedge clk);
    end
    chk("bp_hold", 64'(stable), 64'd1);
    chk("bp_none_sent", 64'(got_q.size()), 64'd0);
    tx_ready = 1'b1;
    wait_idle("bp", 100);
    repeat (3) @(negedge clk);
    drain("bp_tx");

    // garbage in IDLE
    a0 = n_acc;
    send(8'h00); send(8'hFF);
    repeat (3) @(negedge clk);
    chk("garbage_busy", 64'(busy), 64'd0);
    chk("garbage_noacc", 64'(n_acc), 64'(a0));
    chk("garbage_overrun", 64'(overrun), 64'd0);

    // overrun during ACCESS, command still completes
    model_rdata = 16'hBEEF;
    exp_q.push_back(8'hBE);
    exp_q.push_back(8'hEF);
    send(8'h52); send(8'h00); send(8'h00); send(8'h09);
    send(8'h11);
    chk("ovr_set", 64'(overrun), 64'd1);
    wait_idle("ovr", 100);
    chk("ovr_addr", 64'(acc_addr), 64'h00009);
    chk("ovr_hold", 64'(overrun), 64'd1);
    drain("ovr_tx");

    // address masking
    model_rdata = 16'h0102;
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h02);
    send(8'h52); send(8'hFE); send(8'hFF); send(8'hFF);
    wait_idle("mask1", 100);
    chk("mask1_addr", 64'(acc_addr), 64'h0FFFF);
    drain("mask1_tx");
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h02);
    send(8'h52); send(8'hFF); send(8'h00); send(8'h00);
    wait_idle("mask2", 100);
    chk("mask2_addr", 64'(acc_addr), 64'h10000);
    drain("mask2_tx");

    // reset mid-ACCESS
    model_on = 1'b0;
    send(8'h57); send(8'h00); send(8'h00);
    send(8'h01); send(8'h55); send(8'hAA);
    chk("rst_mid_en", 64'(ram_en), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_outs", outs(), 64'd0);
    rst = 1'b0;
    model_on = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_mid_notx", 64'(got_q.size()), 64'd0);
    chk("rst_mid_idle", 64'(busy), 64'd0);

`ifdef RAM_TIMEOUT_EN
    model_on = 1'b0;
    exp_q.push_back(8'h45);
    send(8'h52); send(8'h00); send(8'h00); send(8'h03);
    wait_idle("tmo", 2000);
    chk("tmo_en_cycles", 64'(en_cycles), 64'd1024);
    drain("tmo_tx");
    model_on = 1'b1;
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
